// File: rtl/phold_pkg.sv
// phold_pkg: shared types and constants for the PHOLD engine.
//   event_t  - queued event {lp, ts}
//   state_e  - engine FSM states
//   MC_*     - memory-controller command/size encodings
//   LFSR_*   - event generator seed and feedback taps
package phold_pkg;

  localparam int QDEPTH = 32;
  localparam int QIDX_W = $clog2(QDEPTH);

  localparam logic [2:0] MC_CMD_RD  = 3'd1;
  localparam logic [1:0] MC_SIZE_8B = 2'd3;

  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback is the XOR
  // of bits 0,2,3,5 and enters at bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic [7:0]  lp;
    logic [15:0] ts;
  } event_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_SELECT,
    S_MEMREQ,
    S_MEMWAIT,
    S_GEN,
    S_DONE
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {^(l & LFSR_TAPS), l[15:1]};
  endfunction

endpackage

// File: rtl/phold_mc_if.sv
// phold_mc_if: memory-controller request/response bus, NUM_MC_PORTS wide.
//   master - engine side: drives requests and response stall
//   slave  - memory side: drives request stall and responses
interface phold_mc_if #(
  parameter int NUM_MC_PORTS    = 16,
  parameter int MC_RTNCTL_WIDTH = 32
);
  logic [NUM_MC_PORTS-1:0]                      mc_rq_vld;
  logic [NUM_MC_PORTS-1:0][2:0]                 mc_rq_cmd;
  logic [NUM_MC_PORTS-1:0][3:0]                 mc_rq_scmd;
  logic [NUM_MC_PORTS-1:0][47:0]                mc_rq_vadr;
  logic [NUM_MC_PORTS-1:0][1:0]                 mc_rq_size;
  logic [NUM_MC_PORTS-1:0][MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
  logic [NUM_MC_PORTS-1:0][63:0]                mc_rq_data;
  logic [NUM_MC_PORTS-1:0]                      mc_rq_flush;
  logic [NUM_MC_PORTS-1:0]                      mc_rq_stall;
  logic [NUM_MC_PORTS-1:0]                      mc_rs_vld;
  logic [NUM_MC_PORTS-1:0][2:0]                 mc_rs_cmd;
  logic [NUM_MC_PORTS-1:0][3:0]                 mc_rs_scmd;
  logic [NUM_MC_PORTS-1:0][MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
  logic [NUM_MC_PORTS-1:0][63:0]                mc_rs_data;
  logic [NUM_MC_PORTS-1:0]                      mc_rs_stall;

  modport master (
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
           mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
    input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
           mc_rs_data
  );

  modport slave (
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
           mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
    output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
           mc_rs_data
  );
endinterface

// File: rtl/phold_event_queue.sv
// phold_event_queue: 32-entry unordered event store with min-ts extraction.
//   push_i/push_ev_i - insert into the lowest free slot
//   pop_i            - remove the entry currently shown on min_ev_o
//   min_ev_o         - valid entry with smallest ts (ties: lowest index)
//   min_ts_o         - ts field of min_ev_o
//   empty_o          - no valid entries
// Push and pop may occur in the same cycle; the slot freed by the pop is
// available to the push, so a full queue can still swap an entry.
module phold_event_queue
  import phold_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  event_t      push_ev_i,
  input  logic        pop_i,
  output event_t      min_ev_o,
  output logic [15:0] min_ts_o,
  output logic        empty_o
);

  logic [QDEPTH-1:0] vld_q;
  event_t            ev_q [QDEPTH];

  logic [QIDX_W-1:0] min_idx;
  logic              min_found;
  logic [QDEPTH-1:0] avail;
  logic [QIDX_W-1:0] free_idx;
  logic              free_found;

  always_comb begin
    min_idx   = '0;
    min_found = 1'b0;
    min_ev_o  = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      // strict '<' keeps the earliest index on equal timestamps
      if (vld_q[i] && (!min_found || ev_q[i].ts < min_ev_o.ts)) begin
        min_found = 1'b1;
        min_idx   = QIDX_W'(i);
        min_ev_o  = ev_q[i];
      end
    end
  end

  assign min_ts_o = min_ev_o.ts;
  assign empty_o  = ~|vld_q;

  always_comb begin
    avail = ~vld_q;
    if (pop_i && min_found) avail[min_idx] = 1'b1;
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (avail[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = QIDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      if (pop_i && min_found) vld_q[min_idx] <= 1'b0;
      if (push_i && free_found) begin
        vld_q[free_idx] <= 1'b1;
        ev_q[free_idx]  <= push_ev_i;
      end
    end
  end

endmodule

// File: rtl/phold_engine.sv
// phold_engine: sequential PHOLD event-processing kernel.
//   clk, rst_n        - clock, synchronous active-low reset (held while idle)
//   sim_end           - end timestamp; run stops when min ts >= sim_end
//   addr              - base byte address of the LP state array
//   num_init_events   - seed count (capped at queue depth)
//   lp_mask           - mask applied to every generated LP id
//   num_memcall       - reads issued on MC port 0 per processed event
//   gvt, rtn_vld      - final GVT and one-cycle done pulse
//   mc                - MC request/response bus (only port 0 active)
//   total_*, avg_*    - run statistics; avg_* are raw cycle sums
module phold_engine
  import phold_pkg::*;
#(
  parameter int NUM_MC_PORTS    = 16,
  parameter int MC_RTNCTL_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sim_end,
  input  logic [47:0] addr,
  input  logic [7:0]  num_init_events,
  input  logic [7:0]  lp_mask,
  input  logic [3:0]  num_memcall,
  output logic [15:0] gvt,
  output logic        rtn_vld,
  phold_mc_if.master  mc,
  output logic [63:0] total_cycles,
  output logic [63:0] total_events,
  output logic [63:0] total_stalls,
  output logic [63:0] total_antimsg,
  output logic [63:0] total_q_conf,
  output logic [63:0] avg_mem_time,
  output logic [63:0] avg_proc_time
);

  state_e      state_q;
  logic [5:0]  idx_q;
  event_t      cur_q;
  logic [15:0] lfsr_q;
  logic [3:0]  k_q;
  logic [4:0]  rsp_q;
  logic        rq_vld_q;
  logic [47:0] rq_vadr_q;
  logic [3:0]  rq_rtnctl_q;
  logic [15:0] gvt_q;
  logic        rtn_vld_q;
  logic [63:0] cyc_q, events_q, stalls_q, mem_q, proc_q;

  logic        q_push, q_pop, q_empty;
  event_t      q_push_ev, q_min;
  logic [15:0] q_min_ts;
  logic [5:0]  nseed;
  logic [3:0]  k_nxt;
  logic [4:0]  rsp_sum;
  logic        rq_stall0, rs_vld0;

  assign nseed     = (num_init_events > 8'd32) ? 6'd32 : num_init_events[5:0];
  assign k_nxt     = k_q + 4'd1;
  assign rq_stall0 = mc.mc_rq_stall[0];
  assign rs_vld0   = mc.mc_rs_vld[0];
  // responses may land while requests are still being issued
  assign rsp_sum   = rsp_q + {4'd0, rs_vld0};

  phold_event_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (q_push),
    .push_ev_i (q_push_ev),
    .pop_i     (q_pop),
    .min_ev_o  (q_min),
    .min_ts_o  (q_min_ts),
    .empty_o   (q_empty)
  );

  always_comb begin
    q_push    = 1'b0;
    q_push_ev = '0;
    q_pop     = 1'b0;
    case (state_q)
      S_INIT: begin
        q_push       = (nseed != 6'd0);
        q_push_ev.lp = {2'b00, idx_q} & lp_mask;
        q_push_ev.ts = {10'd0, idx_q};
      end
      S_SELECT: q_pop = !q_empty && (q_min_ts < sim_end);
      S_GEN: begin
        q_push       = 1'b1;
        q_push_ev.lp = lfsr_q[15:8] & lp_mask;
        q_push_ev.ts = cur_q.ts + {12'd0, lfsr_q[3:0]} + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      cur_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      k_q         <= '0;
      rsp_q       <= '0;
      rq_vld_q    <= 1'b0;
      rq_vadr_q   <= '0;
      rq_rtnctl_q <= '0;
      gvt_q       <= '0;
      rtn_vld_q   <= 1'b0;
      cyc_q       <= '0;
      events_q    <= '0;
      stalls_q    <= '0;
      mem_q       <= '0;
      proc_q      <= '0;
    end else begin
      rtn_vld_q <= 1'b0;
      if (state_q != S_DONE) cyc_q <= cyc_q + 64'd1;
      if (rq_vld_q && rq_stall0) stalls_q <= stalls_q + 64'd1;

      case (state_q)
        S_INIT: begin
          if (nseed == 6'd0) begin
            state_q   <= S_DONE;
            gvt_q     <= sim_end;
            rtn_vld_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 6'd1;
            if (idx_q == nseed - 6'd1) state_q <= S_SELECT;
          end
        end

        S_SELECT: begin
          proc_q <= proc_q + 64'd1;
          // every pop is followed by a push, so empty cannot occur in a
          // seeded run; finishing at sim_end keeps the FSM safe regardless
          if (q_empty || q_min_ts >= sim_end) begin
            state_q   <= S_DONE;
            gvt_q     <= q_empty ? sim_end : q_min_ts;
            rtn_vld_q <= 1'b1;
          end else begin
            cur_q   <= q_min;
            k_q     <= '0;
            rsp_q   <= '0;
            state_q <= S_MEMREQ;
          end
        end

        S_MEMREQ: begin
          mem_q <= mem_q + 64'd1;
          rsp_q <= rsp_sum;
          if (!rq_vld_q) begin
            // first MEMREQ cycle sets up request 0
            if (num_memcall == 4'd0) begin
              state_q <= S_GEN;
            end else begin
              rq_vld_q    <= 1'b1;
              rq_vadr_q   <= addr + {33'd0, cur_q.lp, 4'd0, 3'b000};
              rq_rtnctl_q <= 4'd0;
            end
          end else if (!rq_stall0) begin
            if (k_q == num_memcall - 4'd1) begin
              rq_vld_q <= 1'b0;
              state_q  <= S_MEMWAIT;
            end else begin
              k_q         <= k_nxt;
              rq_vadr_q   <= addr + {33'd0, cur_q.lp, k_nxt, 3'b000};
              rq_rtnctl_q <= k_nxt;
            end
          end
        end

        S_MEMWAIT: begin
          mem_q <= mem_q + 64'd1;
          rsp_q <= rsp_sum;
          if (rsp_sum >= {1'b0, num_memcall}) state_q <= S_GEN;
        end

        S_GEN: begin
          proc_q   <= proc_q + 64'd1;
          events_q <= events_q + 64'd1;
          lfsr_q   <= lfsr_next(lfsr_q);
          state_q  <= S_SELECT;
        end

        default: ;
      endcase
    end
  end

  always_comb begin
    mc.mc_rq_vld          = '0;
    mc.mc_rq_cmd          = '0;
    mc.mc_rq_scmd         = '0;
    mc.mc_rq_vadr         = '0;
    mc.mc_rq_size         = '0;
    mc.mc_rq_rtnctl       = '0;
    mc.mc_rq_data         = '0;
    mc.mc_rq_flush        = '0;
    mc.mc_rs_stall        = '0;
    mc.mc_rq_vld[0]       = rq_vld_q;
    mc.mc_rq_cmd[0]       = MC_CMD_RD;
    mc.mc_rq_size[0]      = MC_SIZE_8B;
    mc.mc_rq_vadr[0]      = rq_vadr_q;
    mc.mc_rq_rtnctl[0]    = MC_RTNCTL_WIDTH'(rq_rtnctl_q);
  end

  // response payload and inactive ports carry nothing the engine needs
  logic unused_mc;
  assign unused_mc = ^{mc.mc_rq_stall[NUM_MC_PORTS-1:1], mc.mc_rs_vld[NUM_MC_PORTS-1:1],
                       mc.mc_rs_cmd, mc.mc_rs_scmd, mc.mc_rs_rtnctl, mc.mc_rs_data};

  assign gvt           = gvt_q;
  assign rtn_vld       = rtn_vld_q;
  assign total_cycles  = cyc_q;
  assign total_events  = events_q;
  assign total_stalls  = stalls_q;
  assign total_antimsg = '0;
  assign total_q_conf  = '0;
  assign avg_mem_time  = mem_q;
  assign avg_proc_time = proc_q;

endmodule

// File: tb/tb_phold_engine.sv
module tb_phold_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sim_end = '0;
  logic [47:0] addr = '0;
  logic [7:0]  num_init_events = '0, lp_mask = '0;
  logic [3:0]  num_memcall = '0;
  logic [15:0] gvt;
  logic        rtn_vld;
  logic [63:0] total_cycles, total_events, total_stalls, total_antimsg;
  logic [63:0] total_q_conf, avg_mem_time, avg_proc_time;

  always #5 clk = ~clk;

  phold_mc_if #(.NUM_MC_PORTS(16), .MC_RTNCTL_WIDTH(32)) mc ();

  phold_engine #(.NUM_MC_PORTS(16), .MC_RTNCTL_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .sim_end(sim_end), .addr(addr),
    .num_init_events(num_init_events), .lp_mask(lp_mask), .num_memcall(num_memcall),
    .gvt(gvt), .rtn_vld(rtn_vld), .mc(mc),
    .total_cycles(total_cycles), .total_events(total_events), .total_stalls(total_stalls),
    .total_antimsg(total_antimsg), .total_q_conf(total_q_conf),
    .avg_mem_time(avg_mem_time), .avg_proc_time(avg_proc_time)
  );

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model: always-ready unless stalled, 1-cycle response
  int          stall_cfg = 0;
  logic        hold_rsp = 1'b0;
  int          stall_left = 0, pend = 0, req_cnt = 0, rtn_cnt = 0;
  logic        acc_prev = 1'b0, st, rs, held_bad = 1'b0, stall_seen = 1'b0, oth_bad = 1'b0;
  logic [47:0] stall_vadr;
  logic [31:0] stall_rtn;
  logic [47:0] req_vadr [4];
  logic [31:0] req_rtn  [4];
  logic [2:0]  req_cmd  [4];
  logic [1:0]  req_size [4];

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_left = stall_cfg; req_cnt = 0; rtn_cnt = 0;
      held_bad = 1'b0; stall_seen = 1'b0; oth_bad = 1'b0;
    end
    if (rtn_vld === 1'b1) rtn_cnt++;
    pend += int'(acc_prev);
    rs = 1'b0;
    if (!hold_rsp && pend > 0) begin rs = 1'b1; pend--; end
    mc.mc_rs_vld    = {15'd0, rs};
    mc.mc_rs_cmd    = '0;
    mc.mc_rs_scmd   = '0;
    mc.mc_rs_rtnctl = '0;
    mc.mc_rs_data   = '0;
    st = rst_n && mc.mc_rq_vld[0] && stall_left > 0;
    if (st) begin
      stall_left--;
      if (stall_seen && (mc.mc_rq_vadr[0] !== stall_vadr || mc.mc_rq_rtnctl[0] !== stall_rtn))
        held_bad = 1'b1;
      stall_seen = 1'b1;
      stall_vadr = mc.mc_rq_vadr[0];
      stall_rtn  = mc.mc_rq_rtnctl[0];
    end
    mc.mc_rq_stall = {15'd0, st};
    acc_prev = rst_n && mc.mc_rq_vld[0] && !st;
    if (acc_prev) begin
      if (req_cnt < 4) begin
        req_vadr[req_cnt] = mc.mc_rq_vadr[0];
        req_rtn[req_cnt]  = mc.mc_rq_rtnctl[0];
        req_cmd[req_cnt]  = mc.mc_rq_cmd[0];
        req_size[req_cnt] = mc.mc_rq_size[0];
      end
      req_cnt++;
    end
    if (rst_n && (mc.mc_rq_vld[15:1] != 0 || mc.mc_rq_flush != 0 || mc.mc_rs_stall != 0))
      oth_bad = 1'b1;
  end

  // ---------------- reference model of one run (1-cycle memory, stalls on first request)
  logic [15:0] m_gvt;
  longint      m_ev, m_cyc, m_mem, m_proc;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic bit0;
    bit0 = l[0] ^ l[2] ^ l[3] ^ l[5];
    return (l >> 1) | (16'(bit0) << 15);
  endfunction

  task automatic model(input int n, input int m, input logic [15:0] se, input int stalls);
    logic        qv [32];
    logic [15:0] qt [32];
    logic [15:0] l;
    int ns, mi, per;
    ns = (n > 32) ? 32 : n;
    for (int i = 0; i < 32; i++) begin qv[i] = (i < ns); qt[i] = 16'(i); end
    l = 16'hACE1; m_ev = 0;
    if (ns == 0) begin
      m_gvt = se; m_cyc = 1; m_mem = 0; m_proc = 0;
      return;
    end
    while (m_ev < 100000) begin
      mi = -1;
      for (int i = 0; i < 32; i++)
        if (qv[i] && (mi < 0 || qt[i] < qt[mi])) mi = i;
      if (qt[mi] >= se) break;
      qv[mi] = 1'b0;
      for (int i = 0; i < 32; i++)
        if (!qv[i]) begin qv[i] = 1'b1; qt[i] = qt[mi] + {12'd0, l[3:0]} + 16'd1; break; end
      l = lfsr_step(l);
      m_ev++;
    end
    m_gvt  = qt[mi];
    per    = (m == 0) ? 1 : m + 2;
    m_mem  = m_ev * per + ((m_ev > 0 && m > 0) ? stalls : 0);
    m_cyc  = ns + m_ev * 2 + m_mem + 1;
    m_proc = 2 * m_ev + 1;
  endtask

  // ---------------- one complete run: reset, release, wait for done, capture
  logic [15:0] r_gvt;
  logic [63:0] r_ev, r_cyc, r_stall, r_mem, r_proc, r_anti, r_qconf;

  task automatic run(input string nm, input logic [7:0] n, input logic [3:0] m,
                     input logic [15:0] se, input logic [7:0] mask, input logic [47:0] a,
                     input int stalls);
    int c;
    num_init_events = n; num_memcall = m; sim_end = se; lp_mask = mask; addr = a;
    stall_cfg = stalls;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk({nm, ".rst_rtn_vld"}, 64'(rtn_vld), 64'd0);
    chk({nm, ".rst_gvt"}, 64'(gvt), 64'd0);
    chk({nm, ".rst_rq_vld"}, 64'(mc.mc_rq_vld), 64'd0);
    chk({nm, ".rst_cycles"}, total_cycles, 64'd0);
    rst_n = 1'b1;
    c = 0;
    while (rtn_vld !== 1'b1 && c < 20000) begin @(negedge clk); #1; c++; end
    chk({nm, ".done_seen"}, 64'(rtn_vld === 1'b1), 64'd1);
    r_gvt = gvt; r_ev = total_events; r_cyc = total_cycles; r_stall = total_stalls;
    r_mem = avg_mem_time; r_proc = avg_proc_time; r_anti = total_antimsg; r_qconf = total_q_conf;
    repeat (4) @(negedge clk);
    #1;
    chk({nm, ".one_pulse"}, 64'(rtn_cnt), 64'd1);
    chk({nm, ".gvt_hold"}, 64'(gvt), 64'(r_gvt));
    chk({nm, ".cyc_frozen"}, total_cycles, r_cyc);
    chk({nm, ".other_ports_zero"}, 64'(oth_bad), 64'd0);
  endtask

  logic [15:0] s_gvt;
  logic [63:0] s_ev, s_cyc, s_mem, s_proc, t3_cyc;

  initial begin
    int c;

    // 1: no seeds -> immediate done, gvt = sim_end
    run("noseed", 8'd0, 4'd0, 16'd100, 8'hFF, 48'h0, 0);
    chk("noseed.gvt", 64'(r_gvt), 64'd100);
    chk("noseed.events", r_ev, 64'd0);
    chk("noseed.cycles", r_cyc, 64'd1);
    chk("noseed.reqs", 64'(req_cnt), 64'd0);

    // 2: one seed at ts 0 with sim_end 0 -> done at first select
    run("endzero", 8'd1, 4'd0, 16'd0, 8'hFF, 48'h0, 0);
    chk("endzero.gvt", 64'(r_gvt), 64'd0);
    chk("endzero.events", r_ev, 64'd0);
    chk("endzero.reqs", 64'(req_cnt), 64'd0);
    chk("endzero.cycles", r_cyc, 64'd2);

    // 3: first event is lp 0 -> reads at 0x1000/0x1008
    run("memrd", 8'd4, 4'd2, 16'd30, 8'hFF, 48'h1000, 0);
    model(4, 2, 16'd30, 0);
    chk("memrd.vadr0", req_vadr[0], 64'h1000);
    chk("memrd.vadr1", req_vadr[1], 64'h1008);
    chk("memrd.rtn0", 64'(req_rtn[0]), 64'd0);
    chk("memrd.rtn1", 64'(req_rtn[1]), 64'd1);
    chk("memrd.cmd", 64'(req_cmd[0]), 64'd1);
    chk("memrd.size", 64'(req_size[1]), 64'd3);
    chk("memrd.gvt", 64'(r_gvt), 64'(m_gvt));
    chk("memrd.events", r_ev, 64'(m_ev));
    chk("memrd.reqs", 64'(req_cnt), 64'(m_ev * 2));
    chk("memrd.cycles", r_cyc, 64'(m_cyc));
    chk("memrd.mem_time", r_mem, 64'(m_mem));
    chk("memrd.proc_time", r_proc, 64'(m_proc));
    chk("memrd.stalls", r_stall, 64'd0);
    t3_cyc = r_cyc;

    // 4: same run, first request stalled 5 cycles
    run("stall", 8'd4, 4'd2, 16'd30, 8'hFF, 48'h1000, 5);
    model(4, 2, 16'd30, 5);
    chk("stall.stalls", r_stall, 64'd5);
    chk("stall.held", 64'(held_bad), 64'd0);
    chk("stall.seen", 64'(stall_seen), 64'd1);
    chk("stall.vadr0", req_vadr[0], 64'h1000);
    chk("stall.cycles_plus5", r_cyc, t3_cyc + 64'd5);
    chk("stall.mem_time", r_mem, 64'(m_mem));
    chk("stall.events", r_ev, 64'(m_ev));

    // 5: longer run against the reference model
    run("long", 8'd8, 4'd1, 16'd200, 8'h0F, 48'h2000, 0);
    model(8, 1, 16'd200, 0);
    chk("long.gvt_ge_end", 64'(r_gvt >= 16'd200), 64'd1);
    chk("long.gvt", 64'(r_gvt), 64'(m_gvt));
    chk("long.events", r_ev, 64'(m_ev));
    chk("long.cycles", r_cyc, 64'(m_cyc));
    chk("long.mem_time", r_mem, 64'(m_mem));
    chk("long.proc_time", r_proc, 64'(m_proc));
    chk("long.antimsg", r_anti, 64'd0);
    chk("long.q_conf", r_qconf, 64'd0);
    s_gvt = r_gvt; s_ev = r_ev; s_cyc = r_cyc; s_mem = r_mem; s_proc = r_proc;

    // 6: abort the same run in MEMWAIT, then restart it
    num_init_events = 8'd8; num_memcall = 4'd1; sim_end = 16'd200;
    lp_mask = 8'h0F; addr = 48'h2000; stall_cfg = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    c = 0;
    while (req_cnt < 3 && c < 2000) begin @(negedge clk); #1; c++; end
    chk("abort.reached_req3", 64'(req_cnt >= 3), 64'd1);
    hold_rsp = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("abort.not_done", 64'(rtn_vld), 64'd0);
    chk("abort.stuck_reqs", 64'(req_cnt), 64'd3);
    hold_rsp = 1'b0;  // the held response lands during the coming reset
    run("restart", 8'd8, 4'd1, 16'd200, 8'h0F, 48'h2000, 0);
    chk("restart.gvt", 64'(r_gvt), 64'(s_gvt));
    chk("restart.events", r_ev, s_ev);
    chk("restart.cycles", r_cyc, s_cyc);
    chk("restart.mem_time", r_mem, s_mem);
    chk("restart.proc_time", r_proc, s_proc);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
